cpu_counters: RTL and testbench



---
 rtl/pck_isa_zicsr.sv | 16 +
 rtl/cpu_counter64.sv | 33 +++
 rtl/cpu_counters.sv | 135 +++++++++++++
 tb/tb_cpu_counters.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pck_isa_zicsr.sv
// Zicsr CSR addresses and mcountinhibit bit positions used by the counter unit.
// Constants only; no logic, no latency, no backpressure.
package pck_isa_zicsr;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MTIMECMP      = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMPH     = 12'h7C1;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

    localparam int MCOUNTINHIBIT_CY = 0;
    localparam int MCOUNTINHIBIT_IR = 2;

endpackage

// File: rtl/cpu_counter64.sv
// 64-bit counter with independent 32-bit half writes; a write beats the increment.
// Latency 1 cycle (registered output); no backpressure.
module cpu_counter64 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wr_data,
    output logic [63:0] o_count
);

    logic [63:0] count_nxt;

    // A half write keeps the other half as-is: no increment, no carry that cycle.
    always_comb begin
        count_nxt = o_count;
        if (i_wr_lo)
            count_nxt = {o_count[63:32], i_wr_data};
        else if (i_wr_hi)
            count_nxt = {i_wr_data, o_count[31:0]};
        else if (i_inc)
            count_nxt = o_count + 64'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_count <= 64'd0;
        else
            o_count <= count_nxt;
    end

endmodule

// File: rtl/cpu_counters.sv
// Machine counters (mcycle, minstret, mtime, mcountinhibit); CPU_COUNTERS_MTIMECMP_EN adds mtimecmp + timer irq.
// Latency 1 cycle, all outputs registered; no backpressure.
module cpu_counters
    import pck_isa_zicsr::*;
#(
    parameter int p_ext_rvzicsr = 0,
    parameter int p_mtime_div   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_count_en,
    input  logic        i_retire,
    input  logic        i_wr_en,
    input  logic [11:0] i_addr,
    input  logic [31:0] i_wr_data,
    output logic [63:0] o_mcycle,
    output logic [63:0] o_minstret,
    output logic [63:0] o_mtime,
    output logic [31:0] o_mcountinhibit,
`ifdef CPU_COUNTERS_MTIMECMP_EN
    output logic [63:0] o_mtimecmp,
`endif
    output logic        o_timer_irq
);

    if (p_mtime_div < 1 || p_mtime_div > 65535) begin : g_bad_div
        $error("cpu_counters: p_mtime_div must be in 1..65535");
    end

    if (p_ext_rvzicsr != 0) begin : g_counters
        localparam logic [15:0] DIV_LAST = 16'(p_mtime_div - 1);

        logic        inhibit_cy;
        logic        inhibit_ir;
        logic [15:0] prescale_q;
        logic        mtime_tick;
        logic        wr_inhibit;

        assign wr_inhibit = i_wr_en && (i_addr == CSR_MCOUNTINHIBIT);
        assign mtime_tick = (prescale_q == DIV_LAST);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                prescale_q <= 16'd0;
                inhibit_cy <= 1'b0;
                inhibit_ir <= 1'b0;
            end else begin
                prescale_q <= mtime_tick ? 16'd0 : prescale_q + 16'd1;
                if (wr_inhibit) begin
                    inhibit_cy <= i_wr_data[MCOUNTINHIBIT_CY];
                    inhibit_ir <= i_wr_data[MCOUNTINHIBIT_IR];
                end
            end
        end

        always_comb begin
            o_mcountinhibit                   = 32'd0;
            o_mcountinhibit[MCOUNTINHIBIT_CY] = inhibit_cy;
            o_mcountinhibit[MCOUNTINHIBIT_IR] = inhibit_ir;
        end

        cpu_counter64 u_mcycle (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (i_count_en && !inhibit_cy),
            .i_wr_lo   (i_wr_en && (i_addr == CSR_MCYCLE)),
            .i_wr_hi   (i_wr_en && (i_addr == CSR_MCYCLEH)),
            .i_wr_data (i_wr_data),
            .o_count   (o_mcycle)
        );

        cpu_counter64 u_minstret (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (i_retire && i_count_en && !inhibit_ir),
            .i_wr_lo   (i_wr_en && (i_addr == CSR_MINSTRET)),
            .i_wr_hi   (i_wr_en && (i_addr == CSR_MINSTRETH)),
            .i_wr_data (i_wr_data),
            .o_count   (o_minstret)
        );

        // mtime is read-only and ignores count enable and inhibit.
        cpu_counter64 u_mtime (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (mtime_tick),
            .i_wr_lo   (1'b0),
            .i_wr_hi   (1'b0),
            .i_wr_data (32'd0),
            .o_count   (o_mtime)
        );

`ifdef CPU_COUNTERS_MTIMECMP_EN
        logic [63:0] mtimecmp_q;
        logic [63:0] mtimecmp_nxt;
        logic [63:0] mtime_nxt;

        always_comb begin
            mtimecmp_nxt = mtimecmp_q;
            if (i_wr_en && (i_addr == CSR_MTIMECMP))
                mtimecmp_nxt = {mtimecmp_q[63:32], i_wr_data};
            else if (i_wr_en && (i_addr == CSR_MTIMECMPH))
                mtimecmp_nxt = {i_wr_data, mtimecmp_q[31:0]};
        end

        assign mtime_nxt  = mtime_tick ? o_mtime + 64'd1 : o_mtime;
        assign o_mtimecmp = mtimecmp_q;

        // Compare next values so the irq always agrees with the visible mtime/mtimecmp pair.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                mtimecmp_q  <= '1;
                o_timer_irq <= 1'b0;
            end else begin
                mtimecmp_q  <= mtimecmp_nxt;
                o_timer_irq <= (mtime_nxt >= mtimecmp_nxt);
            end
        end
`else
        assign o_timer_irq = 1'b0;
`endif
    end else begin : g_no_counters
        logic unused_inputs;
        assign unused_inputs   = ^{i_clk, i_rst_n, i_count_en, i_retire, i_wr_en, i_addr, i_wr_data};
        assign o_mcycle        = 64'd0;
        assign o_minstret      = 64'd0;
        assign o_mtime         = 64'd0;
        assign o_mcountinhibit = 32'd0;
        assign o_timer_irq     = 1'b0;
`ifdef CPU_COUNTERS_MTIMECMP_EN
        assign o_mtimecmp      = 64'd0;
`endif
    end

endmodule

// File: tb/tb_cpu_counters.sv
// Directed bench for cpu_counters: expectations queued at drive time, popped after the clock edge.
module tb_cpu_counters;
    import pck_isa_zicsr::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        count_en;
    logic        retire;
    logic        wr_en;
    logic [11:0] addr;
    logic [31:0] wr_data;

    logic [63:0] mcycle, minstret, mtime;
    logic [31:0] minh;
    logic        irq;
    logic [63:0] c4, i4, t4;
    logic [31:0] h4;
    logic        q4;
    logic [63:0] z_cyc, z_ins, z_tim;
    logic [31:0] z_inh;
    logic        z_irq;
`ifdef CPU_COUNTERS_MTIMECMP_EN
    logic [63:0] mtimecmp, m4, z_cmp;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_counters #(.p_ext_rvzicsr(1), .p_mtime_div(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_count_en(count_en), .i_retire(retire),
        .i_wr_en(wr_en), .i_addr(addr), .i_wr_data(wr_data),
        .o_mcycle(mcycle), .o_minstret(minstret), .o_mtime(mtime),
        .o_mcountinhibit(minh),
`ifdef CPU_COUNTERS_MTIMECMP_EN
        .o_mtimecmp(mtimecmp),
`endif
        .o_timer_irq(irq)
    );

    cpu_counters #(.p_ext_rvzicsr(1), .p_mtime_div(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_count_en(count_en), .i_retire(retire),
        .i_wr_en(wr_en), .i_addr(addr), .i_wr_data(wr_data),
        .o_mcycle(c4), .o_minstret(i4), .o_mtime(t4),
        .o_mcountinhibit(h4),
`ifdef CPU_COUNTERS_MTIMECMP_EN
        .o_mtimecmp(m4),
`endif
        .o_timer_irq(q4)
    );

    cpu_counters #(.p_ext_rvzicsr(0), .p_mtime_div(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_count_en(count_en), .i_retire(retire),
        .i_wr_en(wr_en), .i_addr(addr), .i_wr_data(wr_data),
        .o_mcycle(z_cyc), .o_minstret(z_ins), .o_mtime(z_tim),
        .o_mcountinhibit(z_inh),
`ifdef CPU_COUNTERS_MTIMECMP_EN
        .o_mtimecmp(z_cmp),
`endif
        .o_timer_irq(z_irq)
    );

    task automatic expect_val(input string tag, input logic [63:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check_val(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL sb_empty: observed %h required an expectation", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) n_pass++;
            else $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        addr    = 12'h000;
        wr_data = 32'h0;
    endtask

    logic [4:0]  pat;
    logic [63:0] tgt;

    initial begin
        rst_n = 1'b0; count_en = 1'b0; retire = 1'b0;
        idle();
        #12;
        expect_val("rst_mcycle", 64'd0);   expect_val("rst_minstret", 64'd0);
        expect_val("rst_mtime", 64'd0);    expect_val("rst_minh", 64'd0);
        expect_val("rst_irq", 64'd0);      expect_val("rst_mtime_div4", 64'd0);
        check_val(mcycle); check_val(minstret); check_val(mtime);
        check_val(64'(minh)); check_val(64'(irq)); check_val(t4);

        rst_n = 1'b1; count_en = 1'b1;
        repeat (10) tick();
        expect_val("run10_mcycle", 64'd10); expect_val("run10_minstret", 64'd0);
        expect_val("run10_mtime", 64'd10);
        check_val(mcycle); check_val(minstret); check_val(mtime);

        repeat (7) tick();
        expect_val("div4_mtime", 64'd4); expect_val("run17_mtime", 64'd17);
        check_val(t4); check_val(mtime);

        // Half writes and the low-to-high carry after they land.
        csr_wr(CSR_MCYCLE, 32'hFFFF_FFFF);
        expect_val("wr_mcycle_lo", 64'h0000_0000_FFFF_FFFF);
        tick(); check_val(mcycle);
        csr_wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
        expect_val("wr_mcycle_hi", 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); check_val(mcycle);
        idle();
        expect_val("mcycle_wrap", 64'd0);
        tick(); check_val(mcycle);
        expect_val("mcycle_after_wrap", 64'd1);
        tick(); check_val(mcycle);

        csr_wr(CSR_MINSTRET, 32'd5); retire = 1'b1;
        expect_val("minstret_wr_wins", 64'd5); expect_val("mcycle_during_wr", 64'd2);
        tick(); check_val(minstret); check_val(mcycle);
        retire = 1'b0;
        csr_wr(CSR_MINSTRETH, 32'h12);
        expect_val("wr_minstret_hi", 64'h0000_0012_0000_0005);
        tick(); check_val(minstret);

        // Inhibit write: the write cycle still counts under the old setting.
        csr_wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
        expect_val("minh_all", 64'h5); expect_val("mcycle_inh_wr_cycle", 64'd4);
        tick(); check_val(64'(minh)); check_val(mcycle);
        idle(); retire = 1'b1;
        repeat (3) tick();
        expect_val("inh_mcycle_frozen", 64'd4);
        expect_val("inh_minstret_frozen", 64'h0000_0012_0000_0005);
        expect_val("inh_mtime_runs", 64'(cyc));
        check_val(mcycle); check_val(minstret); check_val(mtime);
        csr_wr(CSR_MCOUNTINHIBIT, 32'h0);
        expect_val("clr_minh", 64'h0); expect_val("clr_cycle_still_inh", 64'd4);
        expect_val("clr_minstret_still_inh", 64'h0000_0012_0000_0005);
        tick(); check_val(64'(minh)); check_val(mcycle); check_val(minstret);
        idle(); retire = 1'b0;

        count_en = 1'b0;
        repeat (3) tick();
        expect_val("halt_mcycle", 64'd4); expect_val("halt_mtime", 64'(cyc));
        check_val(mcycle); check_val(mtime);
        count_en = 1'b1;

        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            retire = pat[i];
            tick();
        end
        retire = 1'b0;
        expect_val("retire3_minstret", 64'h0000_0012_0000_0008);
        expect_val("retire3_mcycle", 64'd9);
        check_val(minstret); check_val(mcycle);

        csr_wr(CSR_MCOUNTINHIBIT, 32'h4);
        expect_val("minh_ir", 64'h4);
        tick(); check_val(64'(minh));
        idle();
        for (int i = 0; i < 5; i++) begin
            retire = pat[i];
            tick();
        end
        retire = 1'b0;
        expect_val("ir_minstret_frozen", 64'h0000_0012_0000_0008);
        expect_val("ir_mcycle_runs", 64'd15);
        check_val(minstret); check_val(mcycle);

        csr_wr(12'h123, 32'hFFFF_FFFF);
        expect_val("bad_addr_mcycle", 64'd16);
        expect_val("bad_addr_minstret", 64'h0000_0012_0000_0008);
        expect_val("bad_addr_minh", 64'h4);
        tick(); check_val(mcycle); check_val(minstret); check_val(64'(minh));
        idle();

        expect_val("noext_mcycle", 64'd0); expect_val("noext_minstret", 64'd0);
        expect_val("noext_mtime", 64'd0);  expect_val("noext_minh", 64'd0);
        expect_val("noext_irq", 64'd0);
        check_val(z_cyc); check_val(z_ins); check_val(z_tim);
        check_val(64'(z_inh)); check_val(64'(z_irq));

`ifdef CPU_COUNTERS_MTIMECMP_EN
        expect_val("mtimecmp_rst", 64'hFFFF_FFFF_FFFF_FFFF); expect_val("irq_idle", 64'd0);
        check_val(mtimecmp); check_val(64'(irq));
        csr_wr(CSR_MTIMECMPH, 32'h0);
        expect_val("mtimecmp_hi0", 64'h0000_0000_FFFF_FFFF); expect_val("irq_hi0", 64'd0);
        tick(); check_val(mtimecmp); check_val(64'(irq));
        tgt = 64'(cyc) + 64'd4;
        csr_wr(CSR_MTIMECMP, tgt[31:0]);
        tick(); idle();
        tick(); tick();
        expect_val("pre_cmp_mtime", tgt - 64'd1); expect_val("pre_cmp_irq", 64'd0);
        check_val(mtime); check_val(64'(irq));
        tick();
        expect_val("cmp_mtime", tgt); expect_val("cmp_irq", 64'd1);
        check_val(mtime); check_val(64'(irq));
        tick();
        expect_val("irq_held", 64'd1);
        check_val(64'(irq));
        csr_wr(CSR_MTIMECMPH, 32'h1);
        expect_val("raise_cmp", {32'h1, tgt[31:0]}); expect_val("irq_drop", 64'd0);
        tick(); check_val(mtimecmp); check_val(64'(irq));
        idle();
`endif

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_mcycle", 64'd0); expect_val("arst_minstret", 64'd0);
        expect_val("arst_mtime", 64'd0);  expect_val("arst_minh", 64'd0);
        expect_val("arst_irq", 64'd0);    expect_val("arst_mtime_div4", 64'd0);
        check_val(mcycle); check_val(minstret); check_val(mtime);
        check_val(64'(minh)); check_val(64'(irq)); check_val(t4);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        tick();
        expect_val("post_rst_mcycle", 64'd1); expect_val("post_rst_mtime", 64'd1);
        expect_val("post_rst_minstret", 64'd0);
        check_val(mcycle); check_val(mtime); check_val(minstret);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL sb_leftover: observed %0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
